dsc_sng_tx: RTL
===============

# dsc_sng_tx

Deterministic stochastic-number generator (transmitter) for the DSC datapath. It captures a WIDTH-bit binary operand and emits its unary/thermometer bitstream LANES bits per cycle, one frame of 2**WIDTH bits per operand. The ones-count over a frame equals the operand exactly, so a downstream parallel accumulator recovers it. Chained generators advance through a clock-enable (`step_in`/`ctr_overflow`) instead of ripple clocks, which gives the nested sweep used by multi-operand multipliers.

## Interface
- WIDTH, 5, operand width; frame length is 2**WIDTH bits.
- LANES, 2, bits emitted per advance; power of 2, 1..2**WIDTH.
- REPEAT, 0, 0 = single frame then idle; 1 = wrap and restart the frame indefinitely.
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable; gates every state change except reset.
- start  in  1  request to load `bin_in`; accepted when `ready & en`.
- abort  in  1  terminate the current frame.
- bin_in  in  WIDTH  operand, 0..2**WIDTH-1.
- step_in  in  1  advance enable; tie high for the innermost generator.
- ready  out  1  idle, can accept `start`.
- sn_out  out  LANES  stream bits; lane k = bit c+k of the frame.
- sn_valid  out  1  `sn_out` meaningful (RUN).
- ctr_overflow  out  1  advance that wraps the frame; drives the next generator's `step_in`.
- done  out  1  one-cycle pulse after a completed single frame.

## Operation
- FSM has two states: IDLE and RUN.
  - IDLE -> RUN on `en & start`. This captures `bin_in` into `val` and clears `ctr`.
  - RUN -> IDLE on `en & abort` (no `done`).
  - RUN -> IDLE on `en & adv & last` when REPEAT=0. This also pulses `done`.
  - `abort` has priority over advance.
- `adv` = RUN & `en` & `step_in`. `last` = (`ctr` == 2**WIDTH-LANES).
- `ctr` is WIDTH bits. It adds LANES on `adv`. It wraps to 0 on `adv & last`. When REPEAT=1 the FSM stays in RUN after the wrap.
- `sn_out[k]` = RUN & ((`ctr`+k) < `val`). The comparison is done at WIDTH+1 bits so no intermediate wraps.
- `ctr_overflow` = `adv & last`. It is combinational so chains advance in the same cycle.
- `start` in RUN is ignored. `bin_in` is sampled only on acceptance.
- `en` low freezes all state. `sn_out` and `sn_valid` hold their values.
- `abort` in IDLE has no effect.

## Timing
- Reset values: state IDLE, `ctr`=0, `val`=0. Outputs: `ready`=1, `sn_out`=0, `sn_valid`=0, `ctr_overflow`=0, `done`=0.
- Reset mid-frame returns to the reset values immediately. No `done` is produced.
- Latency: `start` accepted at edge T gives the first `sn_valid` in cycle T+1 with `ctr`=0.
- A frame takes 2**WIDTH/LANES advances. With `step_in`=1 that is 2**WIDTH/LANES cycles.
- `done` is a registered pulse in the cycle after the final advance. `ready`=1 in that same cycle. `start` may be accepted in that cycle.
- `sn_out`, `sn_valid` and `ready` are decoded from registered state. `ctr_overflow` is combinational from `step_in`.

## Structure
- Shared package `dsc_pkg`:
  - state enum (`DSC_IDLE`, `DSC_RUN`);
  - function `dsc_last_ctr(WIDTH, LANES)`;
  - elaboration-time check that LANES is a power of 2 and ≤ 2**WIDTH.
- No sub-module. The lane comparators are a generate loop.

## Test plan
- WIDTH=5, LANES=2, `step_in`=1, `start` with `bin_in`=5:
  - `sn_out` = 11, 11, 01, then 00 for the remaining 13 cycles;
  - ones total 5;
  - `ctr_overflow` in RUN cycle 16, `done` in cycle 17, `ready`=1.
- Boundary operands:
  - `bin_in`=0 gives 16 cycles of 00.
  - `bin_in`=31 gives 15 cycles of 11, the last cycle 01 (lane0=1), ones total 31.
- `step_in` toggled every cycle with `bin_in`=9:
  - frame spans 32 cycles;
  - `sn_out` is held on non-step cycles;
  - ones counted only on `adv` total 9.
- Chain: inner generator (REPEAT=1, `bin_in`=3) with its `ctr_overflow` driving the outer generator's `step_in` (REPEAT=0, `bin_in`=20):
  - outer advances once per 16 cycles;
  - outer `done` at cycle 257;
  - AND-combined lane products over the run total 3·20=60.
- `abort` in RUN cycle 7:
  - IDLE next cycle, `sn_valid`=0, no `done`;
  - a `start` issued during RUN cycles 1–6 has no effect.
- `rst` asserted asynchronously in RUN cycle 4: all outputs return to their reset values at once. A new `start` after release produces a full frame.

Source files
------------

// File: rtl/dsc_sng_tx_pkg.sv
// Shared types and elaboration helpers for the deterministic stochastic-number datapath.
package dsc_pkg;

    typedef enum logic [0:0] {
        DSC_IDLE = 1'b0,
        DSC_RUN  = 1'b1
    } dsc_state_e;

    // Counter value at which the next advance completes the frame.
    function automatic int unsigned dsc_last_ctr(input int unsigned width,
                                                 input int unsigned lanes);
        return (32'd1 << width) - lanes;
    endfunction

    function automatic bit dsc_lanes_ok(input int unsigned width, input int unsigned lanes);
        return (lanes != 0) && ((lanes & (lanes - 1)) == 0) && (lanes <= (32'd1 << width));
    endfunction

endpackage

// File: rtl/dsc_sng_tx_if.sv
// Control/stream bundle of one stochastic-number generator; the generator uses the slave side.
interface dsc_sng_tx_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned LANES = 2
) ();
    logic             en;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] bin_in;
    logic             step_in;
    logic             ready;
    logic [LANES-1:0] sn_out;
    logic             sn_valid;
    logic             ctr_overflow;
    logic             done;

    modport master (
        output en, start, abort, bin_in, step_in,
        input  ready, sn_out, sn_valid, ctr_overflow, done
    );

    modport slave (
        input  en, start, abort, bin_in, step_in,
        output ready, sn_out, sn_valid, ctr_overflow, done
    );
endinterface

// File: rtl/dsc_sng_tx.sv
// Thermometer-code stochastic-number transmitter: LANES frame bits per advance, 2**WIDTH per frame.
module dsc_sng_tx
    import dsc_pkg::*;
#(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned LANES  = 2,
    parameter bit          REPEAT = 1'b0
) (
    input logic          clk,
    input logic          rst,
    dsc_sng_tx_if.slave  bus_io
);

    localparam int unsigned      LastCtr  = dsc_last_ctr(WIDTH, LANES);
    localparam logic [WIDTH-1:0] LastCtrW = LastCtr[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LanesInc = WIDTH'(LANES);

    if (!dsc_lanes_ok(WIDTH, LANES)) begin : g_lanes_chk
        $error("dsc_sng_tx: LANES must be a power of 2 no larger than 2**WIDTH");
    end

    dsc_state_e       state_q, state_d;
    logic [WIDTH-1:0] ctr_q, ctr_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             done_q, done_d;

    logic             run;
    logic             adv;
    logic             last;
    logic [LANES-1:0] sn;

    assign run  = (state_q == DSC_RUN);
    assign adv  = run & bus_io.en & bus_io.step_in;
    assign last = (ctr_q == LastCtrW);

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        val_d   = val_q;
        done_d  = done_q;
        if (bus_io.en) begin
            done_d = 1'b0;
            case (state_q)
                DSC_IDLE: begin
                    if (bus_io.start) begin
                        state_d = DSC_RUN;
                        val_d   = bus_io.bin_in;
                        ctr_d   = '0;
                    end
                end
                DSC_RUN: begin
                    // Abort wins over a coincident advance, so no done is raised.
                    if (bus_io.abort) begin
                        state_d = DSC_IDLE;
                    end else if (adv) begin
                        ctr_d = last ? '0 : ctr_q + LanesInc;
                        if (last && !REPEAT) begin
                            state_d = DSC_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DSC_IDLE;
            ctr_q   <= '0;
            val_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            val_q   <= val_d;
            done_q  <= done_d;
        end
    end

    // One extra bit keeps ctr+k from wrapping before the compare.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH:0] pos;
        assign pos   = {1'b0, ctr_q} + (WIDTH + 1)'(k);
        assign sn[k] = run & (pos < {1'b0, val_q});
    end

    assign bus_io.sn_out       = sn;
    assign bus_io.sn_valid     = run;
    assign bus_io.ready        = (state_q == DSC_IDLE);
    assign bus_io.ctr_overflow = adv & last;
    assign bus_io.done         = done_q;

endmodule
